// File: rtl/axi4_lite_master_rw.sv
// axi4_lite_master_rw
// Single-outstanding AXI4-Lite master. Accepts one core request (read or
// write) at a time from a fetch/LSU stage, runs it on the AXI4-Lite channels
// and returns a one-cycle response pulse with data and the AXI response code.
//
// Ports
//   iClock, iResetN        clock (rising edge), async active-low reset
//   iReq*                  core request: valid/ready handshake, write flag,
//                          address, write data, byte strobes
//   oResp*                 one-cycle response pulse, read data (0 on write),
//                          RRESP/BRESP code
//   pAXI4_ar_* / r_*       read address / read data channels
//   pAXI4_aw_* / w_* / b_* write address / write data / write response
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | ready for a request; latches addr/data/mask on acceptance
// S_RD_ADDR | ar_valid high until the AR handshake
// S_RD_DATA | r_ready high until the R handshake; captures data and RRESP
// S_WR_REQ  | aw_valid / w_valid, each dropped after its own handshake
// S_WR_RESP | b_ready high until the B handshake; captures BRESP
// S_RESP    | oRespValid pulse for one cycle, then back to S_IDLE
module axi4_lite_master_rw #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int RESP_WIDTH = 2
) (
    input  logic                  iClock,
    input  logic                  iResetN,

    input  logic                  iReqValid,
    output logic                  oReqReady,
    input  logic                  iReqWrite,
    input  logic [ADDR_WIDTH-1:0] iReqAddr,
    input  logic [DATA_WIDTH-1:0] iReqData,
    input  logic [MASK_WIDTH-1:0] iReqMask,

    output logic                  oRespValid,
    output logic [DATA_WIDTH-1:0] oRespData,
    output logic [RESP_WIDTH-1:0] oRespCode,

    input  logic                  pAXI4_ar_ready,
    output logic                  pAXI4_ar_valid,
    output logic [ADDR_WIDTH-1:0] pAXI4_ar_bits_addr,

    input  logic                  pAXI4_r_valid,
    input  logic [DATA_WIDTH-1:0] pAXI4_r_bits_data,
    input  logic [RESP_WIDTH-1:0] pAXI4_r_bits_resp,
    output logic                  pAXI4_r_ready,

    input  logic                  pAXI4_aw_ready,
    output logic                  pAXI4_aw_valid,
    output logic [ADDR_WIDTH-1:0] pAXI4_aw_bits_addr,

    input  logic                  pAXI4_w_ready,
    output logic                  pAXI4_w_valid,
    output logic [DATA_WIDTH-1:0] pAXI4_w_bits_data,
    output logic [MASK_WIDTH-1:0] pAXI4_w_bits_strb,

    input  logic                  pAXI4_b_valid,
    input  logic [RESP_WIDTH-1:0] pAXI4_b_bits_resp,
    output logic                  pAXI4_b_ready
);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("axi4_lite_master_rw: DATA_WIDTH must be 32 or 64");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [MASK_WIDTH-1:0] mask_q;
    logic                  aw_done;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [RESP_WIDTH-1:0] resp_code_q;

    logic accept;
    logic ar_hs;
    logic r_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;

    assign accept = (state == S_IDLE) && iReqValid;
    assign ar_hs  = pAXI4_ar_valid && pAXI4_ar_ready;
    assign r_hs   = pAXI4_r_valid  && pAXI4_r_ready;
    assign aw_hs  = pAXI4_aw_valid && pAXI4_aw_ready;
    assign w_hs   = pAXI4_w_valid  && pAXI4_w_ready;
    assign b_hs   = pAXI4_b_valid  && pAXI4_b_ready;

    // State register
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (iReqValid) begin
                    state_nxt = iReqWrite ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (ar_hs) state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (r_hs) state_nxt = S_RESP;
            end
            S_WR_REQ: begin
                // A channel counts as finished if it completed earlier or
                // completes on this edge; covers either order and same-cycle.
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (b_hs) state_nxt = S_RESP;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: valids/readies are decoded from state and done flags only,
    // never from the slave's ready/valid inputs.
    always_comb begin
        oReqReady      = 1'b0;
        pAXI4_ar_valid = 1'b0;
        pAXI4_r_ready  = 1'b0;
        pAXI4_aw_valid = 1'b0;
        pAXI4_w_valid  = 1'b0;
        pAXI4_b_ready  = 1'b0;
        oRespValid     = 1'b0;
        case (state)
            S_IDLE:    oReqReady      = 1'b1;
            S_RD_ADDR: pAXI4_ar_valid = 1'b1;
            S_RD_DATA: pAXI4_r_ready  = 1'b1;
            S_WR_REQ: begin
                pAXI4_aw_valid = !aw_done;
                pAXI4_w_valid  = !w_done;
            end
            S_WR_RESP: pAXI4_b_ready  = 1'b1;
            S_RESP:    oRespValid     = 1'b1;
            default: begin
                oReqReady = 1'b0;
            end
        endcase
    end

    // Request latch, per-channel done flags and response capture
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            resp_data_q <= '0;
            resp_code_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= iReqAddr;
                data_q  <= iReqData;
                mask_q  <= iReqMask;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (r_hs) begin
                resp_data_q <= pAXI4_r_bits_data;
                resp_code_q <= pAXI4_r_bits_resp;
            end
            if (b_hs) begin
                resp_data_q <= '0;
                resp_code_q <= pAXI4_b_bits_resp;
            end
        end
    end

    assign pAXI4_ar_bits_addr = addr_q;
    assign pAXI4_aw_bits_addr = addr_q;
    assign pAXI4_w_bits_data  = data_q;
    assign pAXI4_w_bits_strb  = mask_q;
    assign oRespData          = resp_data_q;
    assign oRespCode          = resp_code_q;

endmodule

// File: tb/tb_axi4_lite_master_rw.sv
// tb_axi4_lite_master_rw
// Bench for axi4_lite_master_rw. A transaction-level slave/scoreboard runs on
// the falling edge: every accepted request is recorded with the wait states
// the slave will insert, and the expected response, channel contents and
// latency are derived from that record.
module tb_axi4_lite_master_rw;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int RW = 2;

    logic          iClock = 1'b0;
    logic          iResetN = 1'b0;
    logic          iReqValid = 1'b0;
    logic          oReqReady;
    logic          iReqWrite = 1'b0;
    logic [AW-1:0] iReqAddr = '0;
    logic [DW-1:0] iReqData = '0;
    logic [MW-1:0] iReqMask = '0;
    logic          oRespValid;
    logic [DW-1:0] oRespData;
    logic [RW-1:0] oRespCode;
    logic          pAXI4_ar_ready = 1'b0;
    logic          pAXI4_ar_valid;
    logic [AW-1:0] pAXI4_ar_bits_addr;
    logic          pAXI4_r_valid = 1'b0;
    logic [DW-1:0] pAXI4_r_bits_data = '0;
    logic [RW-1:0] pAXI4_r_bits_resp = '0;
    logic          pAXI4_r_ready;
    logic          pAXI4_aw_ready = 1'b0;
    logic          pAXI4_aw_valid;
    logic [AW-1:0] pAXI4_aw_bits_addr;
    logic          pAXI4_w_ready = 1'b0;
    logic          pAXI4_w_valid;
    logic [DW-1:0] pAXI4_w_bits_data;
    logic [MW-1:0] pAXI4_w_bits_strb;
    logic          pAXI4_b_valid = 1'b0;
    logic [RW-1:0] pAXI4_b_bits_resp = '0;
    logic          pAXI4_b_ready;

    axi4_lite_master_rw #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .RESP_WIDTH(RW)
    ) dut (
        .iClock(iClock), .iResetN(iResetN),
        .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqWrite(iReqWrite),
        .iReqAddr(iReqAddr), .iReqData(iReqData), .iReqMask(iReqMask),
        .oRespValid(oRespValid), .oRespData(oRespData), .oRespCode(oRespCode),
        .pAXI4_ar_ready(pAXI4_ar_ready), .pAXI4_ar_valid(pAXI4_ar_valid),
        .pAXI4_ar_bits_addr(pAXI4_ar_bits_addr),
        .pAXI4_r_valid(pAXI4_r_valid), .pAXI4_r_bits_data(pAXI4_r_bits_data),
        .pAXI4_r_bits_resp(pAXI4_r_bits_resp), .pAXI4_r_ready(pAXI4_r_ready),
        .pAXI4_aw_ready(pAXI4_aw_ready), .pAXI4_aw_valid(pAXI4_aw_valid),
        .pAXI4_aw_bits_addr(pAXI4_aw_bits_addr),
        .pAXI4_w_ready(pAXI4_w_ready), .pAXI4_w_valid(pAXI4_w_valid),
        .pAXI4_w_bits_data(pAXI4_w_bits_data), .pAXI4_w_bits_strb(pAXI4_w_bits_strb),
        .pAXI4_b_valid(pAXI4_b_valid), .pAXI4_b_bits_resp(pAXI4_b_bits_resp),
        .pAXI4_b_ready(pAXI4_b_ready)
    );

    always #5 iClock = ~iClock;

    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [MW-1:0] mask;
        logic [DW-1:0] rdata;
        logic [RW-1:0] resp;
        int            ar_d, r_d, aw_d, w_d, b_d;
        int            acc_cyc;
    } txn_t;

    txn_t req_q[$];
    int   acc_log[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave behaviour for the next accepted request
    int            cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
    logic [RW-1:0] cfg_resp = '0;
    logic [DW-1:0] cfg_rdata = '0;
    bit            stray_en = 1'b0;

    int cyc = 0;
    bit outstanding = 1'b0;
    bit accepted_flag = 1'b0;
    bit ar_seen, aw_seen, w_seen, aw_done_m, w_done_m, r_pending, b_pending;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, ar_vc, aw_vc, w_vc;

    // Slave model + scoreboard, evaluated on the falling edge
    initial begin
        txn_t t;
        bit   ok;
        int   exp_lat;
        forever begin
            @(negedge iClock);
            cyc++;
            if (!iResetN) begin
                req_q.delete();
                outstanding = 0; accepted_flag = 0;
                ar_seen = 0; aw_seen = 0; w_seen = 0; aw_done_m = 0; w_done_m = 0;
                r_pending = 0; b_pending = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                ar_vc = 0; aw_vc = 0; w_vc = 0;
                pAXI4_ar_ready = 0; pAXI4_aw_ready = 0; pAXI4_w_ready = 0;
                pAXI4_r_valid = 0; pAXI4_b_valid = 0;
                continue;
            end

            check("req_ready", {63'd0, oReqReady}, {63'd0, !outstanding});

            if (oRespValid) begin
                if (req_q.size() == 0) begin
                    check("spurious_resp", 64'd1, 64'd0);
                end else begin
                    t = req_q[0];
                    check("resp_data", oRespData, t.write ? '0 : t.rdata);
                    check("resp_code", oRespCode, t.resp);
                    exp_lat = t.write ? 3 + ((t.aw_d > t.w_d) ? t.aw_d : t.w_d) + t.b_d
                                      : 3 + t.ar_d + t.r_d;
                    check("latency", cyc - t.acc_cyc, exp_lat);
                    void'(req_q.pop_front());
                    outstanding = 0;
                end
            end

            if (iReqValid && oReqReady) begin
                t.write = iReqWrite; t.addr = iReqAddr; t.data = iReqData; t.mask = iReqMask;
                t.rdata = cfg_rdata; t.resp = cfg_resp;
                t.ar_d = cfg_ar; t.r_d = cfg_r; t.aw_d = cfg_aw; t.w_d = cfg_w; t.b_d = cfg_b;
                t.acc_cyc = cyc;
                req_q.push_back(t);
                acc_log.push_back(cyc);
                outstanding = 1;
                accepted_flag = 1;
            end

            // R channel (before AR so data never comes in the AR cycle)
            pAXI4_r_valid = 0;
            pAXI4_r_bits_data = $urandom;
            pAXI4_r_bits_resp = RW'($urandom);
            if (r_pending) begin
                if (r_cnt == 0) begin
                    pAXI4_r_valid = 1;
                    pAXI4_r_bits_data = req_q[0].rdata;
                    pAXI4_r_bits_resp = req_q[0].resp;
                    if (pAXI4_r_ready) r_pending = 0;
                end else begin
                    r_cnt--;
                end
            end else if (pAXI4_r_ready) begin
                check("r_ready_unexpected", 64'd1, 64'd0);
            end else if (stray_en) begin
                pAXI4_r_valid = ($urandom_range(0, 3) == 0);
            end

            // B channel
            pAXI4_b_valid = 0;
            pAXI4_b_bits_resp = RW'($urandom);
            if (b_pending) begin
                if (b_cnt == 0) begin
                    pAXI4_b_valid = 1;
                    pAXI4_b_bits_resp = req_q[0].resp;
                    if (pAXI4_b_ready) b_pending = 0;
                end else begin
                    b_cnt--;
                end
            end else if (pAXI4_b_ready) begin
                check("b_ready_unexpected", 64'd1, 64'd0);
            end else if (stray_en) begin
                pAXI4_b_valid = ($urandom_range(0, 3) == 0);
            end

            // AR channel
            pAXI4_ar_ready = 0;
            if (pAXI4_ar_valid) begin
                ok = (req_q.size() > 0) && !req_q[0].write && !r_pending;
                check("ar_valid_legal", {63'd0, ok}, 64'd1);
                if (ok) begin
                    ar_vc++;
                    if (!ar_seen) begin ar_seen = 1; ar_cnt = req_q[0].ar_d; end
                    if (ar_cnt == 0) begin
                        pAXI4_ar_ready = 1;
                        ar_seen = 0;
                        check("ar_addr", pAXI4_ar_bits_addr, req_q[0].addr);
                        check("ar_valid_cycles", ar_vc, req_q[0].ar_d + 1);
                        ar_vc = 0;
                        r_pending = 1;
                        r_cnt = req_q[0].r_d;
                    end else begin
                        ar_cnt--;
                    end
                end
            end

            // AW and W channels, tracked independently
            pAXI4_aw_ready = 0;
            pAXI4_w_ready = 0;
            if (pAXI4_aw_valid) begin
                ok = (req_q.size() > 0) && req_q[0].write && !aw_done_m && !b_pending;
                check("aw_valid_legal", {63'd0, ok}, 64'd1);
                if (ok) begin
                    aw_vc++;
                    if (!aw_seen) begin aw_seen = 1; aw_cnt = req_q[0].aw_d; end
                    if (aw_cnt == 0) begin
                        pAXI4_aw_ready = 1;
                        aw_seen = 0;
                        aw_done_m = 1;
                        check("aw_addr", pAXI4_aw_bits_addr, req_q[0].addr);
                        check("aw_valid_cycles", aw_vc, req_q[0].aw_d + 1);
                        aw_vc = 0;
                    end else begin
                        aw_cnt--;
                    end
                end
            end
            if (pAXI4_w_valid) begin
                ok = (req_q.size() > 0) && req_q[0].write && !w_done_m && !b_pending;
                check("w_valid_legal", {63'd0, ok}, 64'd1);
                if (ok) begin
                    w_vc++;
                    if (!w_seen) begin w_seen = 1; w_cnt = req_q[0].w_d; end
                    if (w_cnt == 0) begin
                        pAXI4_w_ready = 1;
                        w_seen = 0;
                        w_done_m = 1;
                        check("w_data", pAXI4_w_bits_data, req_q[0].data);
                        check("w_strb", pAXI4_w_bits_strb, req_q[0].mask);
                        check("w_valid_cycles", w_vc, req_q[0].w_d + 1);
                        w_vc = 0;
                    end else begin
                        w_cnt--;
                    end
                end
            end
            if (aw_done_m && w_done_m) begin
                aw_done_m = 0;
                w_done_m = 0;
                b_pending = 1;
                b_cnt = req_q[0].b_d;
            end
        end
    end

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    // Presents a request and returns once it has been accepted; iReqValid is
    // left high so a following call gives back-to-back requests.
    task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m);
        iReqValid = 1; iReqWrite = w; iReqAddr = a; iReqData = d; iReqMask = m;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (accepted_flag) begin
                accepted_flag = 0;
                return;
            end
        end
        check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 500; i++) begin
            if (req_q.size() == 0 && !outstanding) return;
            tick();
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic set_cfg(input int ar, input int r, input int aw, input int w, input int b,
                           input logic [RW-1:0] resp, input logic [DW-1:0] rdata);
        cfg_ar = ar; cfg_r = r; cfg_aw = aw; cfg_w = w; cfg_b = b;
        cfg_resp = resp; cfg_rdata = rdata;
    endtask

    task automatic check_reset_outputs();
        check("rst_ar_valid",  {63'd0, pAXI4_ar_valid}, 64'd0);
        check("rst_ar_addr",   pAXI4_ar_bits_addr, 64'd0);
        check("rst_r_ready",   {63'd0, pAXI4_r_ready}, 64'd0);
        check("rst_aw_valid",  {63'd0, pAXI4_aw_valid}, 64'd0);
        check("rst_aw_addr",   pAXI4_aw_bits_addr, 64'd0);
        check("rst_w_valid",   {63'd0, pAXI4_w_valid}, 64'd0);
        check("rst_w_data",    pAXI4_w_bits_data, 64'd0);
        check("rst_w_strb",    pAXI4_w_bits_strb, 64'd0);
        check("rst_b_ready",   {63'd0, pAXI4_b_ready}, 64'd0);
        check("rst_resp_valid",{63'd0, oRespValid}, 64'd0);
        check("rst_resp_data", oRespData, 64'd0);
        check("rst_resp_code", oRespCode, 64'd0);
    endtask

    initial begin
        int base;
        bit ok;
        repeat (3) tick();
        check_reset_outputs();
        check("rst_req_ready", {63'd0, oReqReady}, 64'd1);
        iResetN = 1;

        // Zero-wait read
        set_cfg(0, 0, 0, 0, 0, 2'd0, 32'hDEADBEEF);
        send(0, 32'h8000_0000, '0, '0);
        iReqValid = 0;
        wait_done();

        // Write, AW delayed 2 cycles, W immediate
        set_cfg(0, 0, 2, 0, 0, 2'd0, '0);
        send(1, 32'hA000_03F8, 32'h1234_5678, 4'h3);
        iReqValid = 0;
        wait_done();

        // W first, AW 4 cycles later; then same-cycle AW/W
        set_cfg(0, 0, 4, 0, 1, 2'd0, '0);
        send(1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF);
        iReqValid = 0;
        wait_done();
        set_cfg(0, 0, 0, 0, 0, 2'd3, '0);
        send(1, 32'h0000_1004, 32'h0BAD_BEEF, 4'hC);
        iReqValid = 0;
        wait_done();

        // SLVERR read after 5-cycle R delay
        set_cfg(1, 5, 0, 0, 0, 2'd2, 32'h5555_AAAA);
        send(0, 32'h0000_2000, '0, '0);
        iReqValid = 0;
        wait_done();

        // Reset while waiting in RD_DATA
        set_cfg(0, 10, 0, 0, 0, 2'd0, 32'h1111_2222);
        send(0, 32'h0000_3000, '0, '0);
        iReqValid = 0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (pAXI4_r_ready) ok = 1;
            else tick();
        end
        check("reach_rd_data", {63'd0, ok}, 64'd1);
        tick();
        iResetN = 0;
        #1;
        check_reset_outputs();
        tick();
        tick();
        iResetN = 1;
        set_cfg(0, 0, 0, 0, 0, 2'd0, 32'h7777_8888);
        send(0, 32'h0000_3004, '0, '0);
        iReqValid = 0;
        wait_done();

        // Back-to-back read/write/read with iReqValid held high
        base = acc_log.size();
        set_cfg(0, 0, 0, 0, 0, 2'd0, 32'hA5A5_0001);
        send(0, 32'h0000_4000, '0, '0);
        set_cfg(0, 0, 0, 0, 0, 2'd2, '0);
        send(1, 32'h0000_4004, 32'h0102_0304, 4'h5);
        set_cfg(0, 0, 0, 0, 0, 2'd3, 32'hA5A5_0003);
        send(0, 32'h0000_4008, '0, '0);
        iReqValid = 0;
        wait_done();
        check("b2b_count", acc_log.size() - base, 3);
        if (acc_log.size() - base == 3) begin
            check("b2b_gap0", acc_log[base + 1] - acc_log[base], 4);
            check("b2b_gap1", acc_log[base + 2] - acc_log[base + 1], 4);
        end

        // Randomized traffic with stray R/B valids outside their states
        stray_en = 1;
        for (int n = 0; n < 60; n++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), RW'($urandom), $urandom);
            send($urandom_range(0, 1) == 1, {$urandom, 2'b00} , $urandom, MW'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                iReqValid = 0;
                repeat ($urandom_range(0, 4)) tick();
            end
        end
        iReqValid = 0;
        wait_done();
        stray_en = 0;
        repeat (3) tick();
        check("queue_empty", req_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
